mm_mem_bridge: RTL
==================

// Module: mm_mem_bridge
// PURPOSE
//  Memory-side stage below the matrix-multiply engine. Accepts its word
//  read/write requests through a small in-order request FIFO and runs them
//  one at a time as Wishbone master cycles into user BRAM (0x3800_0000 window).
//  Read data returns to the engine as a one-cycle response pulse.
//  Faults (bad address, bus timeout) never stall the engine.
// PARAMETERS
//  DEPTH    4             request FIFO entries (power of 2, >=2)
//  BASE     32'h3800_0000 legal address window base
//  SPAN     32'h0000_0400 legal window size in bytes
//  TMO      8'd64         cycles of stb without ack before a bus abort
// PORTS
//  clk        in   1   single clock; all logic on posedge
//  rst        in   1   asynchronous, active-low reset
//  req_val    in   1   engine request valid
//  req_adr    in   32  byte address, word aligned
//  req_dat    in   32  write data
//  req_wrt    in   1   1 = write, 0 = read
//  req_rdy    out  1   request accepted this cycle (engine advances index)
//  rsp_val    out  1   one-cycle read-data pulse, in request order
//  rsp_dat    out  32  read data, valid with rsp_val
//  fin_in     in   1   engine finished
//  done       out  1   sticky: fin_in seen and FIFO empty and bus idle
//  err        out  1   sticky fault flag
//  wb_cyc, wb_stb, wb_we  out 1; wb_sel out 4; wb_adr, wb_dat_w out 32
//  wb_dat_r   in   32  Wishbone read data;  wb_ack in 1  Wishbone ack
// BEHAVIOUR
//  Reset (rst low, any cycle, mid-transfer included): FIFO emptied, FSM IDLE;
//   all outputs 0 (req_rdy 0 only while rst low).
//  req_rdy = !full (combinational). Push on req_val&&req_rdy. When full,
//   no push even if a pop happens the same cycle.
//  FIFO: count 0..DEPTH; rd/wr pointers wrap modulo DEPTH; FIFO entry = {wrt,adr,dat}.
//  FSM IDLE: FIFO non-empty -> pop head into registers, go BUS.
//   Head with adr outside [BASE, BASE+SPAN) or adr[1:0]!=0: no bus cycle;
//   set err; read -> rsp_val with rsp_dat=32'hDEAD_BEEF; stay IDLE.
//  FSM BUS: wb_cyc=wb_stb=1, wb_sel=4'hF, wb_we=wrt, wb_adr/wb_dat_w held.
//   wb_ack -> IDLE next edge; read: rsp_val=1, rsp_dat=wb_dat_r next cycle.
//   Timer counts stb cycles; at TMO without ack -> drop cyc/stb, set err,
//   read -> DEAD_BEEF response; IDLE. Ack ignored outside BUS.
//  Latency: accept in cycle 0, stb from cycle 2, ack in cycle k (k>=2),
//   rsp_val in cycle k+1. BUS always returns through IDLE: max one bus
//   transaction per 2 cycles.
//  Every accepted read yields exactly one rsp_val, strictly in order.
//  Writes produce no response.
//  done set when fin_in has been seen (latched) and count==0 and state IDLE;
//   done/err clear only on reset.
// STRUCTURE
//  Shared package: FSM state encodings (IDLE, BUS), BASE/SPAN defaults,
//   DEAD_BEEF constant, Wishbone sel-all constant.
//  One sub-module: mm_req_fifo (DEPTH x 65-bit, push/pop/full/empty/count).
//  Bridge FSM, timer, and done/err flags live in the top.
// TESTING
//  1 read 0x3800_00C0, ack in 1st stb cycle -> stb cycle 2, rsp_val cycle 3.
//  2 16 back-to-back reads, ack delay 3 -> req_rdy drops at 4 queued;
//    16 rsp in order; no drop/dup.
//  3 write 0x3800_0140 dat 0x1234 -> wb_we=1, sel=F, dat_w=0x1234;
//    no rsp_val.
//  4 read 0x3000_0000 -> no wb_cyc; err=1; rsp_dat=DEAD_BEEF next cycle.
//  5 no ack for 64 stb cycles -> cyc drops, err=1, DEAD_BEEF returned;
//    next request proceeds normally.
//  6 rst low mid-BUS with 3 queued -> all outputs 0 same cycle;
//    after release FIFO empty; fin_in+idle -> done=1.

Source files
------------

// File: rtl/mm_mem_bridge_pkg.sv
// Shared types and constants for the matrix-multiply memory bridge:
// FSM encoding, address window defaults, request entry layout.
package mm_mem_bridge_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    localparam logic [31:0] BASE_DEF   = 32'h3800_0000;
    localparam logic [31:0] SPAN_DEF   = 32'h0000_0400;
    localparam logic [7:0]  TMO_DEF    = 8'd64;
    localparam logic [31:0] DEAD_BEEF  = 32'hDEAD_BEEF;
    localparam logic [3:0]  WB_SEL_ALL = 4'hF;

    // One FIFO entry: 1 + 32 + 32 = 65 bits.
    typedef struct packed {
        logic        wrt;
        logic [31:0] adr;
        logic [31:0] dat;
    } req_t;

    // Offset compare handles adr < base through unsigned wrap-around.
    function automatic logic addr_ok(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
        logic [31:0] off;
        off = adr - base;
        return (off < span) && (adr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mm_mem_bridge_if.sv
// Engine request/response, completion flags and Wishbone bus of the bridge.
// master: the bridge itself; slave: the engine plus the memory it drives.
interface mm_mem_bridge_if;

    logic        req_val;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        req_wrt;
    logic        req_rdy;
    logic        rsp_val;
    logic [31:0] rsp_dat;
    logic        fin_in;
    logic        done;
    logic        err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_ack;

    modport master (
        input  req_val, req_adr, req_dat, req_wrt, fin_in, wb_dat_r, wb_ack,
        output req_rdy, rsp_val, rsp_dat, done, err,
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w
    );

    modport slave (
        output req_val, req_adr, req_dat, req_wrt, fin_in, wb_dat_r, wb_ack,
        input  req_rdy, rsp_val, rsp_dat, done, err,
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_w
    );

endinterface

// File: rtl/mm_req_fifo.sv
// In-order request FIFO, DEPTH x 65-bit entries; push ignored when full,
// pop ignored when empty.
module mm_req_fifo
    import mm_mem_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_t                     push_data,
    input  logic                     pop,
    output req_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mm_mem_bridge.sv
// Memory-side stage below the matrix-multiply engine: queues word requests and
// runs them one at a time as Wishbone cycles, with timeout and fault flags.
module mm_mem_bridge
    import mm_mem_bridge_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] BASE  = BASE_DEF,
    parameter logic [31:0] SPAN  = SPAN_DEF,
    parameter logic [7:0]  TMO   = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mm_mem_bridge_if.master bus
);

    state_e      state_q,   state_d;
    req_t        cur_q,     cur_d;
    logic [7:0]  tmr_q,     tmr_d;
    logic        rsp_val_q, rsp_val_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        err_q,     err_d;
    logic        fin_q,     fin_d;
    logic        done_q,    done_d;

    req_t                   head;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic [$clog2(DEPTH):0] count;
    logic                   bus_act;

    req_t push_data;
    assign push_data = '{wrt: bus.req_wrt, adr: bus.req_adr, dat: bus.req_dat};

    mm_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.req_val),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Ready drops immediately while reset is held, not just after the next edge.
    assign bus.req_rdy = rst && !full;

    assign bus_act      = (state_q == ST_BUS);
    assign bus.wb_cyc   = bus_act;
    assign bus.wb_stb   = bus_act;
    assign bus.wb_we    = bus_act && cur_q.wrt;
    assign bus.wb_sel   = bus_act ? WB_SEL_ALL : 4'h0;
    assign bus.wb_adr   = bus_act ? cur_q.adr : 32'h0;
    assign bus.wb_dat_w = bus_act ? cur_q.dat : 32'h0;

    assign bus.rsp_val = rsp_val_q;
    assign bus.rsp_dat = rsp_dat_q;
    assign bus.err     = err_q;
    assign bus.done    = done_q;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tmr_d     = tmr_q;
        rsp_val_d = 1'b0;
        rsp_dat_d = rsp_dat_q;
        err_d     = err_q;
        pop       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (addr_ok(head.adr, BASE, SPAN)) begin
                        cur_d   = head;
                        tmr_d   = 8'd0;
                        state_d = ST_BUS;
                    end else begin
                        // Faulted request is consumed without a bus cycle.
                        err_d = 1'b1;
                        if (!head.wrt) begin
                            rsp_val_d = 1'b1;
                            rsp_dat_d = DEAD_BEEF;
                        end
                    end
                end
            end
            ST_BUS: begin
                if (bus.wb_ack) begin
                    state_d = ST_IDLE;
                    if (!cur_q.wrt) begin
                        rsp_val_d = 1'b1;
                        rsp_dat_d = bus.wb_dat_r;
                    end
                end else if (tmr_q == TMO - 8'd1) begin
                    // TMO stb cycles without ack: abort so the engine never stalls.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (!cur_q.wrt) begin
                        rsp_val_d = 1'b1;
                        rsp_dat_d = DEAD_BEEF;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fin_d  = fin_q || bus.fin_in;
        done_d = done_q || (fin_d && (count == '0) && (state_q == ST_IDLE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            tmr_q     <= 8'd0;
            rsp_val_q <= 1'b0;
            rsp_dat_q <= 32'h0;
            err_q     <= 1'b0;
            fin_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tmr_q     <= tmr_d;
            rsp_val_q <= rsp_val_d;
            rsp_dat_q <= rsp_dat_d;
            err_q     <= err_d;
            fin_q     <= fin_d;
            done_q    <= done_d;
        end
    end

endmodule
